// File: rtl/des_pkg.sv
// des_pkg: shared types and constant tables for the iterative DES round engine.
// Contents: FSM state enum, key-shift schedule, PC-2 / E / P index tables
// (1-based DES numbering, bit 1 = MSB), width constants and 28-bit rotate
// helpers.
package des_pkg;

    localparam int BLOCK_W  = 64;
    localparam int HALF_W   = 32;
    localparam int CD_W     = 56;
    localparam int SUBKEY_W = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SHIFT_SCHED [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int PC2_TBL [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int E_TBL [1:48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TBL [1:32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // Shift amount for a 1-based round index; anything out of range rotates by 0.
    function automatic logic [1:0] shift_amt(input logic [4:0] idx);
        if (idx >= 5'd1 && idx <= 5'd16) return 2'(SHIFT_SCHED[int'(idx)]);
        return 2'd0;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] v, input logic [1:0] s);
        case (s)
            2'd1:    return {v[26:0], v[27]};
            2'd2:    return {v[25:0], v[27:26]};
            default: return v;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic [1:0] s);
        case (s)
            2'd1:    return {v[0], v[27:1]};
            2'd2:    return {v[1:0], v[27:2]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/des_round_engine_f.sv
// des_f_function: combinational DES round function f = P(S(E(r) ^ k)).
// Ports: r [32:1] right half, k [48:1] round subkey, f [32:1] result.
// All vectors use DES numbering: DES bit i lives at index (width + 1 - i).
module des_f_function
    import des_pkg::*;
(
    input  logic [32:1] r,
    input  logic [48:1] k,
    output logic [32:1] f
);

    // Each S-box is 64 nibbles, row-major (row 0 col 0 in the top nibble).
    localparam logic [255:0] SBOX [1:8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    logic [48:1] e;
    logic [48:1] x;
    logic [32:1] s;

    for (genvar i = 1; i <= 48; i++) begin : g_e
        assign e[49-i] = r[33-E_TBL[i]];
    end

    assign x = e ^ k;

    for (genvar j = 1; j <= 8; j++) begin : g_sbox
        logic [5:0]   chunk;
        logic [5:0]   idx;
        logic [255:0] sel;
        assign chunk = x[54-6*j -: 6];
        // Outer bits pick the row, inner four bits pick the column.
        assign idx   = {chunk[5], chunk[0], chunk[4:1]};
        assign sel   = SBOX[j] << {idx, 2'b00};
        assign s[36-4*j -: 4] = sel[255:252];
    end

    for (genvar i = 1; i <= 32; i++) begin : g_p
        assign f[33-i] = s[33-P_TBL[i]];
    end

endmodule

// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES Feistel core, one round per clock.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_block/key_cd/decrypt
// accept a post-IP block and post-PC-1 key; out_valid/out_ready/out_block return
// the pre-output {R16, L16}; busy is high while rounds are running.
// Subkeys are generated on the fly: encrypt rotates left ahead of PC-2,
// decrypt rotates right (round 1 uses C0D0 unrotated, as C16D16 = C0D0).
module des_round_engine
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:1] in_block,
    input  logic [56:1] key_cd,
    input  logic        decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] out_block,
    output logic        busy
);

    state_t      state, state_next;
    logic [32:1] half_l, half_r;
    logic [56:1] cd;
    logic [4:0]  round;
    logic        mode;
    logic [1:0]  shift;
    logic [28:1] c_rot, d_rot;
    logic [56:1] cd_rot;
    logic [48:1] subkey;
    logic [32:1] f_out;
    logic        accept;
    logic        last_round;

    assign accept     = (state == IDLE) && in_valid && in_ready;
    assign last_round = (round == 5'(NUM_ROUNDS));
    assign busy       = (state == ROUND);

    // Key schedule: rotate this round's CD, then PC-2 in the same cycle.
    always_comb begin
        if (mode) begin
            shift = (round == 5'd1) ? 2'd0 : shift_amt(5'd18 - round);
            c_rot = rotr28(cd[56:29], shift);
            d_rot = rotr28(cd[28:1], shift);
        end else begin
            shift = shift_amt(round);
            c_rot = rotl28(cd[56:29], shift);
            d_rot = rotl28(cd[28:1], shift);
        end
    end

    assign cd_rot = {c_rot, d_rot};

    for (genvar i = 1; i <= 48; i++) begin : g_pc2
        assign subkey[49-i] = cd_rot[57-PC2_TBL[i]];
    end

    des_f_function u_f (
        .r (half_r),
        .k (subkey),
        .f (f_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ROUND;
            ROUND:   if (last_round) state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_block <= '0;
            half_l    <= '0;
            half_r    <= '0;
            cd        <= '0;
            round     <= '0;
            mode      <= 1'b0;
        end else begin
            // Handshake flags follow the state being entered, so in_ready is
            // low throughout DONE and an accept cannot overlap the release.
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: if (accept) begin
                    half_l <= in_block[64:33];
                    half_r <= in_block[32:1];
                    cd     <= key_cd;
                    mode   <= decrypt;
                    round  <= 5'd1;
                end
                ROUND: begin
                    half_l <= half_r;
                    half_r <= half_l ^ f_out;
                    cd     <= cd_rot;
                    round  <= round + 5'd1;
                    // Final swap: pre-output is {R16, L16}.
                    if (last_round) out_block <= {half_l ^ f_out, half_r};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine: directed checks of des_round_engine against the FIPS
// 46-3 worked example, its decrypt inverse and the DES complementation
// property (~P, ~K encrypt to ~C), covering backpressure, ignored input,
// async abort and back-to-back streaming.
module tb_des_round_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        decrypt = 1'b0;
    logic [64:1] in_block = '0;
    logic [56:1] key_cd = '0;
    logic        in_ready, out_valid, busy;
    logic [64:1] out_block;

    int checks = 0;
    int errors = 0;

    localparam logic [64:1] PT    = 64'hCC00CCFF_F0AAF0AA;
    localparam logic [64:1] CT    = 64'h0A4CD995_43423234;
    localparam logic [56:1] KEY   = 56'hF0CCAAF_556678F;
    localparam logic [64:1] PT_N  = 64'h33FF3300_0F550F55;
    localparam logic [64:1] CT_N  = 64'hF5B3266A_BCBDCDCB;
    localparam logic [56:1] KEY_N = 56'h0F33550_AA99870;

    des_round_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .key_cd    (key_cd),
        .decrypt   (decrypt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a block and return one step after the accepting edge.
    task automatic send(input logic [64:1] blk, input logic [56:1] key, input logic dec);
        bit ok;
        ok       = 1'b0;
        in_block = blk;
        key_cd   = key;
        decrypt  = dec;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = in_ready;
            tick();
        end
        chk("accept", 64'(ok), 64'd1);
        in_valid = 1'b0;
        in_block = ~blk;
        key_cd   = ~key;
        decrypt  = ~dec;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    logic [64:1] blks [4];
    logic [56:1] keys [4];
    logic        decs [4];
    logic [64:1] exps [4];

    initial begin
        int lat;
        int sent, got, last_acc;
        bit acc;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_block", 64'(out_block), 64'd0);
        rst = 1'b0;
        tick();
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Encrypt FIPS example, with ignored in_valid pulse mid-operation
        send(PT, KEY, 1'b0);
        chk("enc_busy", 64'(busy), 64'd1);
        chk("enc_in_ready_low", 64'(in_ready), 64'd0);
        chk("enc_k1", 64'(dut.subkey), 64'h1B02EFFC7072);
        tick();
        chk("enc_l1", 64'(dut.half_l), 64'hF0AAF0AA);
        chk("enc_r1", 64'(dut.half_r), 64'hEF4A6544);
        in_block = CT;
        key_cd   = KEY_N;
        decrypt  = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("busy_in_ready_low", 64'(in_ready), 64'd0);
        wait_done(3, lat);
        chk("enc_latency", 64'(lat), 64'd16);
        chk("enc_result", 64'(out_block), 64'(CT));

        // Backpressure: result held while out_ready is low
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_block", 64'(out_block), 64'(CT));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        release_out();

        // Decrypt round trip
        send(CT, KEY, 1'b1);
        wait_done(0, lat);
        chk("dec_latency", 64'(lat), 64'd16);
        chk("dec_result", 64'(out_block), 64'(PT));
        release_out();

        // Async abort at round 8
        send(PT, KEY, 1'b0);
        repeat (7) tick();
        #3 rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_out_block", 64'(out_block), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_in_ready_back", 64'(in_ready), 64'd1);
        send(PT, KEY, 1'b0);
        wait_done(0, lat);
        chk("post_abort_result", 64'(out_block), 64'(CT));
        release_out();

        // Back-to-back streaming
        blks = '{PT, CT, PT_N, CT_N};
        keys = '{KEY, KEY, KEY_N, KEY_N};
        decs = '{1'b0, 1'b1, 1'b0, 1'b1};
        exps = '{CT, PT, CT_N, PT_N};
        sent = 0;
        got = 0;
        last_acc = 0;
        out_ready = 1'b1;
        in_block = blks[0];
        key_cd   = keys[0];
        decrypt  = decs[0];
        in_valid = 1'b1;
        for (int cyc = 1; cyc <= 200 && got < 4; cyc++) begin
            acc = in_ready && in_valid;
            tick();
            if (out_valid) begin
                chk($sformatf("b2b_out%0d", got), 64'(out_block), 64'(exps[got]));
                got++;
            end
            if (acc) begin
                if (sent > 0) chk("b2b_gap", 64'(cyc - last_acc), 64'd18);
                last_acc = cyc;
                sent++;
                if (sent < 4) begin
                    in_block = blks[sent];
                    key_cd   = keys[sent];
                    decrypt  = decs[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_count", 64'(got), 64'd4);
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
